// File: rtl/tnn_pkg.sv
// Shared types and default sizing for the temporal-neural-network datapath blocks.
// Default parameters, the spike-time entry type, the no-spike code and the volley FIFO state.
package tnn_pkg;

  localparam int DEF_TIME_PERIOD = 8;
  localparam int DEF_NUM_LINES   = 16;
  localparam int DEF_TW          = $clog2(DEF_TIME_PERIOD);

  typedef logic [DEF_TW+1:0] spike_time_t;

  localparam spike_time_t NO_SPIKE = spike_time_t'(DEF_TIME_PERIOD);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } fifo_state_t;

endpackage

// File: rtl/spike_capture.sv
// Per-line first-spike latch: remembers the window time of the first spike seen
// since the last clear.
module spike_capture
  import tnn_pkg::*;
#(
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  localparam int TW = $clog2(TIME_PERIOD)
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [TW:0] i_time,
  input  logic        i_spike,
  input  logic        i_clear,
  output logic        o_seen,
  output logic [TW:0] o_time
);

  localparam logic [TW:0] PERIOD_T = (TW+1)'(TIME_PERIOD);

  logic        r_seen;
  logic [TW:0] r_time;
  logic        w_take;

  // Out-of-window times never capture, and only the first spike of a window is kept.
  assign w_take = i_spike & ~r_seen & (i_time < PERIOD_T);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_seen <= 1'b0;
      r_time <= '0;
    end else if (i_clear) begin
      r_seen <= 1'b0;
    end else if (w_take) begin
      r_seen <= 1'b1;
      r_time <= i_time;
    end
  end

  assign o_seen = r_seen;
  assign o_time = r_time;

endmodule

// File: rtl/spike_time_encoder.sv
// Encodes per-cycle spike pulses into one first-spike-time volley per gamma window
// and delivers completed volleys through a 2-entry valid/ready FIFO.
module spike_time_encoder
  import tnn_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  localparam int TW = $clog2(TIME_PERIOD),
  localparam int EW = TW + 2
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [TW:0]             time_val,
  input  logic [NUM_LINES-1:0]    spikes_in,
  input  logic                    flush,
  output logic                    vol_valid,
  input  logic                    vol_ready,
  output logic [NUM_LINES*EW-1:0] spike_times,
  output logic                    overflow,
  output logic [7:0]              drop_cnt
);

  localparam logic [TW:0]   LAST_T      = (TW+1)'(TIME_PERIOD - 1);
  localparam logic [EW-1:0] EMPTY_ENTRY = EW'(TIME_PERIOD);

  fifo_state_t             r_state;
  fifo_state_t             w_state_next;
  logic [NUM_LINES*EW-1:0] r_head;
  logic [NUM_LINES*EW-1:0] r_tail;
  logic                    r_overflow;
  logic [7:0]              r_drop_cnt;

  logic                    w_boundary;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_clear;
  logic                    w_drop;
  logic [NUM_LINES-1:0]    w_seen;
  logic [TW:0]             w_time [NUM_LINES];
  logic [NUM_LINES*EW-1:0] w_volley;

  assign w_boundary = (time_val == LAST_T);
  assign w_push     = w_boundary & ~flush;
  assign w_pop      = vol_valid & vol_ready;
  assign w_clear    = w_boundary | flush;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    spike_capture #(
      .TIME_PERIOD(TIME_PERIOD)
    ) u_capture (
      .clk    (clk),
      .rst_l  (rst_l),
      .i_time (time_val),
      .i_spike(spikes_in[g]),
      .i_clear(w_clear),
      .o_seen (w_seen[g]),
      .o_time (w_time[g])
    );
  end

  // A spike arriving in the boundary cycle itself still belongs to the closing window.
  always_comb begin
    w_volley = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (w_seen[i]) begin
        w_volley[i*EW +: EW] = {1'b0, w_time[i]};
      end else if (w_boundary && spikes_in[i]) begin
        w_volley[i*EW +: EW] = {1'b0, LAST_T};
      end else begin
        w_volley[i*EW +: EW] = EMPTY_ENTRY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_push) w_state_next = ONE;
        ONE: begin
          if (w_push && !w_pop) w_state_next = FULL;
          else if (!w_push && w_pop) w_state_next = EMPTY;
        end
        FULL: begin
          if (!w_push && w_pop) w_state_next = ONE;
          else if (w_push && !w_pop) w_drop = 1'b1;
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    vol_valid   = (r_state != EMPTY);
    spike_times = vol_valid ? r_head : {NUM_LINES{EMPTY_ENTRY}};
  end

  // Head always holds the oldest volley; a pop with a concurrent push shifts tail forward.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_head <= {NUM_LINES{EMPTY_ENTRY}};
      r_tail <= {NUM_LINES{EMPTY_ENTRY}};
    end else if (!flush) begin
      case (r_state)
        EMPTY: if (w_push) r_head <= w_volley;
        ONE: begin
          if (w_push && w_pop) r_head <= w_volley;
          else if (w_push) r_tail <= w_volley;
        end
        FULL: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail <= w_volley;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spike_time_encoder.sv
// Self-checking bench for spike_time_encoder: directed scenarios plus random windows,
// compared every cycle against a queue-based model of windows and volley delivery.
module tb_spike_time_encoder;

  localparam int NL = 4;
  localparam int TP = 8;
  localparam int EW = 5;
  localparam int VW = NL * EW;

  logic          clk       = 1'b0;
  logic          rst_l     = 1'b1;
  logic [3:0]    time_val  = '0;
  logic [NL-1:0] spikes_in = '0;
  logic          flush     = 1'b0;
  logic          vol_ready = 1'b0;
  logic          vol_valid;
  logic [VW-1:0] spike_times;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] expQ[$];
  int            firstSpike[NL];
  logic          expOverflow = 1'b0;
  int            expDrop     = 0;
  int            tNext       = 0;

  spike_time_encoder #(
    .NUM_LINES  (NL),
    .TIME_PERIOD(TP)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .time_val   (time_val),
    .spikes_in  (spikes_in),
    .flush      (flush),
    .vol_valid  (vol_valid),
    .vol_ready  (vol_ready),
    .spike_times(spike_times),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] packVolley(input int e0, input int e1, input int e2, input int e3);
    logic [VW-1:0] v;
    v = {5'(e3), 5'(e2), 5'(e1), 5'(e0)};
    return v;
  endfunction

  function automatic logic [VW:0] expView();
    if (expQ.size() == 0) return {1'b0, packVolley(TP, TP, TP, TP)};
    return {1'b1, expQ[0]};
  endfunction

  function automatic logic [8:0] expStatus();
    return {expOverflow, 8'(expDrop)};
  endfunction

  task automatic clearWindow();
    for (int i = 0; i < NL; i++) firstSpike[i] = TP;
  endtask

  task automatic modelReset();
    expQ.delete();
    clearWindow();
    expOverflow = 1'b0;
    expDrop     = 0;
  endtask

  // Drives one cycle, advances the model across the clock edge, returns at the next negedge.
  task automatic applyStimulus(input int tv, input logic [NL-1:0] sp, input logic rdy, input logic fl);
    logic [VW-1:0] v;
    logic          pop;
    time_val  = 4'(tv);
    spikes_in = sp;
    vol_ready = rdy;
    flush     = fl;
    @(posedge clk);
    if (!rst_l) begin
      modelReset();
    end else begin
      pop = (expQ.size() > 0) && rdy;
      if (tv < TP) begin
        for (int i = 0; i < NL; i++)
          if (sp[i] && firstSpike[i] == TP) firstSpike[i] = tv;
      end
      if (fl) begin
        expQ.delete();
        clearWindow();
      end else begin
        if (pop) void'(expQ.pop_front());
        if (tv == TP - 1) begin
          for (int i = 0; i < NL; i++) v[i*EW +: EW] = EW'(firstSpike[i]);
          if (expQ.size() < 2) begin
            expQ.push_back(v);
          end else begin
            expOverflow = 1'b1;
            if (expDrop < 255) expDrop++;
          end
          clearWindow();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [NL-1:0] sp, input logic rdy, input logic fl);
    applyStimulus(tNext, sp, rdy, fl);
    tNext = (tNext + 1) % TP;
  endtask

  task automatic test_reset();
    #1 rst_l = 1'b0;
    #2;
    checks++;
    if ({vol_valid, spike_times, overflow, drop_cnt} !== {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got %h, want %h", {vol_valid, spike_times, overflow, drop_cnt},
               {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0});
    end
    @(negedge clk);
    applyStimulus(TP - 1, '1, 1'b1, 1'b0);
    checks++;
    if ({vol_valid, spike_times} !== expView()) begin
      failures++;
      $display("[TB] FAIL reset_held: got %h, want %h", {vol_valid, spike_times}, expView());
    end
    rst_l = 1'b1;
    tNext = 0;
  endtask

  task automatic test_first_spike();
    logic [NL-1:0] sp;
    for (int t = 0; t < TP; t++) begin
      sp = '0;
      if (t == 2 || t == 5) sp[0] = 1'b1;
      if (t == 7) sp[2] = 1'b1;
      step(sp, 1'b1, 1'b0);
      checks++;
      if ({vol_valid, spike_times} !== expView()) begin
        failures++;
        $display("[TB] FAIL first_spike_view t=%0d: got %h, want %h", t, {vol_valid, spike_times}, expView());
      end
    end
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, packVolley(2, 8, 7, 8)}) begin
      failures++;
      $display("[TB] FAIL first_spike_volley: got %h, want %h", {vol_valid, spike_times}, {1'b1, packVolley(2, 8, 7, 8)});
    end
  endtask

  task automatic test_all_and_idle();
    for (int t = 0; t < TP; t++) step('1, 1'b1, 1'b0);
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, packVolley(0, 0, 0, 0)}) begin
      failures++;
      $display("[TB] FAIL all_lines_volley: got %h, want %h", {vol_valid, spike_times}, {1'b1, packVolley(0, 0, 0, 0)});
    end
    for (int t = 0; t < TP; t++) begin
      step('0, 1'b1, 1'b0);
      checks++;
      if ({vol_valid, spike_times} !== expView()) begin
        failures++;
        $display("[TB] FAIL idle_view t=%0d: got %h, want %h", t, {vol_valid, spike_times}, expView());
      end
    end
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, packVolley(8, 8, 8, 8)}) begin
      failures++;
      $display("[TB] FAIL idle_volley: got %h, want %h", {vol_valid, spike_times}, {1'b1, packVolley(8, 8, 8, 8)});
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    int            bounds;
    step('0, 1'b1, 1'b0);
    bounds = 0;
    while (bounds < 3) begin
      if (tNext == TP - 1) bounds++;
      step(4'($urandom) & 4'($urandom), 1'b0, 1'b0);
      if (bounds == 1 && tNext == 0) v1 = expQ[0];
      if (bounds == 2 && tNext == 0) v2 = expQ[1];
      checks++;
      if ({vol_valid, spike_times} !== expView()) begin
        failures++;
        $display("[TB] FAIL hold_view b=%0d: got %h, want %h", bounds, {vol_valid, spike_times}, expView());
      end
      if (bounds >= 1) begin
        checks++;
        if (spike_times !== v1) begin
          failures++;
          $display("[TB] FAIL head_stable b=%0d: got %h, want %h", bounds, spike_times, v1);
        end
      end
    end
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL first_drop: got %h, want %h", {overflow, drop_cnt}, {1'b1, 8'd1});
    end
    step('0, 1'b1, 1'b0);
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, v2}) begin
      failures++;
      $display("[TB] FAIL pop_order_second: got %h, want %h", {vol_valid, spike_times}, {1'b1, v2});
    end
    step('0, 1'b1, 1'b0);
    checks++;
    if (vol_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drained: got %b, want 0", vol_valid);
    end
  endtask

  task automatic test_full_pop_push();
    logic [VW-1:0] b;
    int            bounds;
    bounds = 0;
    while (bounds < 3) begin
      if (tNext == TP - 1) bounds++;
      step(4'($urandom), (bounds == 3), 1'b0);
      if (bounds == 2 && tNext == 0) b = expQ[1];
      checks++;
      if ({vol_valid, spike_times, overflow, drop_cnt} !== {expView(), expStatus()}) begin
        failures++;
        $display("[TB] FAIL full_fill_view b=%0d: got %h, want %h", bounds,
                 {vol_valid, spike_times, overflow, drop_cnt}, {expView(), expStatus()});
      end
    end
    checks++;
    if ({vol_valid, spike_times, drop_cnt} !== {1'b1, b, 8'd1}) begin
      failures++;
      $display("[TB] FAIL full_pop_push: got %h, want %h", {vol_valid, spike_times, drop_cnt}, {1'b1, b, 8'd1});
    end
    step('0, 1'b1, 1'b0);
    checks++;
    if (vol_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL still_full: got %b, want 1", vol_valid);
    end
    step('0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_window();
    logic [NL-1:0] sp;
    while (tNext != 0) step(4'($urandom), 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      sp = '0;
      if (t == 3) sp[1] = 1'b1;
      step(sp, 1'b0, 1'b0);
    end
    #2 rst_l = 1'b0;
    modelReset();
    #1;
    checks++;
    if ({vol_valid, spike_times, overflow, drop_cnt} !== {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got %h, want %h", {vol_valid, spike_times, overflow, drop_cnt},
               {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0});
    end
    @(negedge clk);
    step('0, 1'b0, 1'b0);
    rst_l = 1'b1;
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, packVolley(8, 8, 8, 8)}) begin
      failures++;
      $display("[TB] FAIL post_reset_volley: got %h, want %h", {vol_valid, spike_times}, {1'b1, packVolley(8, 8, 8, 8)});
    end
  endtask

  task automatic test_flush();
    logic [NL-1:0] sp;
    for (int t = 0; t < TP; t++) begin
      sp = '0;
      if (t == 1) sp[3] = 1'b1;
      step(sp, 1'b0, (t == TP - 1));
    end
    checks++;
    if ({vol_valid, spike_times, overflow, drop_cnt} !== {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0}) begin
      failures++;
      $display("[TB] FAIL flush_discard: got %h, want %h", {vol_valid, spike_times, overflow, drop_cnt},
               {1'b0, packVolley(TP, TP, TP, TP), 1'b0, 8'd0});
    end
    for (int t = 0; t < TP; t++) begin
      sp = '0;
      if (t == 4) sp[0] = 1'b1;
      step(sp, 1'b1, 1'b0);
    end
    checks++;
    if ({vol_valid, spike_times} !== {1'b1, packVolley(4, 8, 8, 8)}) begin
      failures++;
      $display("[TB] FAIL after_flush_volley: got %h, want %h", {vol_valid, spike_times}, {1'b1, packVolley(4, 8, 8, 8)});
    end
  endtask

  task automatic test_random();
    logic [NL-1:0] sp;
    logic          rdy;
    for (int c = 0; c < 40 * TP; c++) begin
      for (int i = 0; i < NL; i++) sp[i] = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) applyStimulus(TP + $urandom_range(0, TP - 1), sp, rdy, 1'b0);
      else step(sp, rdy, ($urandom_range(0, 63) == 0));
      checks++;
      if ({vol_valid, spike_times, overflow, drop_cnt} !== {expView(), expStatus()}) begin
        failures++;
        $display("[TB] FAIL random_view c=%0d: got %h, want %h", c,
                 {vol_valid, spike_times, overflow, drop_cnt}, {expView(), expStatus()});
      end
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 260 * TP; c++) step(4'($urandom), 1'b0, 1'b0);
    checks++;
    if ({overflow, drop_cnt} !== {1'b1, 8'd255}) begin
      failures++;
      $display("[TB] FAIL drop_saturate: got %h, want %h", {overflow, drop_cnt}, {1'b1, 8'd255});
    end
    checks++;
    if ({vol_valid, spike_times, overflow, drop_cnt} !== {expView(), expStatus()}) begin
      failures++;
      $display("[TB] FAIL saturate_view: got %h, want %h", {vol_valid, spike_times, overflow, drop_cnt},
               {expView(), expStatus()});
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_first_spike();
    test_all_and_idle();
    test_back_to_back();
    test_full_pop_push();
    test_reset_mid_window();
    test_flush();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
